// File: rtl/bpu_pkg.sv
// Shared definitions for the tournament branch predictor: counter reset value,
// saturating counter step and the bit layout of the prediction metadata word.
package bpu_pkg;

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;

    // meta = {ghr_snap, lhr, pred_local, pred_global}, LSB first from pred_global
    localparam int META_PG_BIT  = 0;
    localparam int META_PL_BIT  = 1;
    localparam int META_LHR_LSB = 2;

    function automatic int meta_ghr_lsb(input int lhr_w);
        return META_LHR_LSB + lhr_w;
    endfunction

    function automatic int meta_w(input int ghr_w, input int lhr_w);
        return ghr_w + lhr_w + 2;
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Array of 2-bit saturating counters: asynchronous read, synchronous
// single-port update that steps the addressed counter up or down.
module sat_counter_table
    import bpu_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_up_i
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] cnt_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_WEAK_NT;
        end else if (we_i) begin
            cnt_q[wr_idx_i] <= sat_step(cnt_q[wr_idx_i], wr_up_i);
        end
    end

    // Reads see the pre-update value when they collide with a write.
    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predict_tournament.sv
// Tournament branch predictor (local BHT/PHT vs gshare, arbitrated by a choice
// table). Define BPU_STATS_EN to add branch / mispredict statistics counters.
module branch_predict_tournament
    import bpu_pkg::*;
#(
    parameter int BHT_IDX_W  = 8,
    parameter int LHR_W      = 8,
    parameter int GHR_W      = 8,
    parameter int CPHT_IDX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pcF,
    input  logic                     stallD,
    input  logic                     flushD,
    input  logic                     branchD,
    output logic                     pred_takeD,
    output logic [GHR_W+LHR_W+1:0]   metaD,
    input  logic                     branchM,
    input  logic                     actual_takeM,
    input  logic                     judgeM,
    input  logic [31:0]              pcM,
    input  logic [GHR_W+LHR_W+1:0]   metaM
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispred
`endif
);

    localparam int MW      = meta_w(GHR_W, LHR_W);
    localparam int GHR_LSB = meta_ghr_lsb(LHR_W);

    logic [LHR_W-1:0]      bht_q [1 << BHT_IDX_W];
    logic [GHR_W-1:0]      ghr_q, ghr_d;
    logic                  pred_q;
    logic [MW-1:0]         meta_q;

    // F-stage lookup
    logic [BHT_IDX_W-1:0]  f_bidx;
    logic [LHR_W-1:0]      f_lhr;
    logic [GHR_W-1:0]      f_gidx;
    logic [CPHT_IDX_W-1:0] f_cidx;
    logic [1:0]            l_cnt, g_cnt, c_cnt;
    logic                  f_pl, f_pg, f_pred;

    assign f_bidx = pcF[BHT_IDX_W+1:2];
    assign f_lhr  = bht_q[f_bidx];
    assign f_gidx = ghr_q ^ pcF[GHR_W+1:2];
    assign f_cidx = pcF[CPHT_IDX_W+1:2];
    assign f_pl   = l_cnt[1];
    assign f_pg   = g_cnt[1];
    assign f_pred = c_cnt[1] ? f_pg : f_pl;

    // M-stage training fields, all taken from the carried metadata
    logic [GHR_W-1:0]      m_snap;
    logic [LHR_W-1:0]      m_lhr;
    logic                  m_pl, m_pg;
    logic [BHT_IDX_W-1:0]  m_bidx;
    logic [GHR_W-1:0]      m_gidx;
    logic [CPHT_IDX_W-1:0] m_cidx;

    assign m_snap = metaM[GHR_LSB +: GHR_W];
    assign m_lhr  = metaM[META_LHR_LSB +: LHR_W];
    assign m_pl   = metaM[META_PL_BIT];
    assign m_pg   = metaM[META_PG_BIT];
    assign m_bidx = pcM[BHT_IDX_W+1:2];
    assign m_gidx = m_snap ^ pcM[GHR_W+1:2];
    assign m_cidx = pcM[CPHT_IDX_W+1:2];

    sat_counter_table #(.IDX_W(LHR_W)) u_lpht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx_i (f_lhr),
        .rd_cnt_o (l_cnt),
        .we_i     (branchM),
        .wr_idx_i (m_lhr),
        .wr_up_i  (actual_takeM)
    );

    sat_counter_table #(.IDX_W(GHR_W)) u_gpht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx_i (f_gidx),
        .rd_cnt_o (g_cnt),
        .we_i     (branchM),
        .wr_idx_i (m_gidx),
        .wr_up_i  (actual_takeM)
    );

    // Choice only learns when the two paths disagreed; up means trust global.
    sat_counter_table #(.IDX_W(CPHT_IDX_W)) u_cpht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx_i (f_cidx),
        .rd_cnt_o (c_cnt),
        .we_i     (branchM & (m_pl ^ m_pg)),
        .wr_idx_i (m_cidx),
        .wr_up_i  (m_pg == actual_takeM)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < (1 << BHT_IDX_W); i++) bht_q[i] <= '0;
        end else if (branchM) begin
            bht_q[m_bidx] <= {m_lhr[LHR_W-2:0], actual_takeM};
        end
    end

    // F/D prediction register; flush beats stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_q <= 1'b0;
            meta_q <= '0;
        end else if (flushD) begin
            pred_q <= 1'b0;
            meta_q <= '0;
        end else if (!stallD) begin
            pred_q <= f_pred;
            meta_q <= {ghr_q, f_lhr, f_pl, f_pg};
        end
    end

    assign pred_takeD = branchD & pred_q;
    assign metaD      = meta_q;

    // Mispredict repair overrides any speculative shift in the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (branchM & judgeM)
            ghr_d = {m_snap[GHR_W-2:0], actual_takeM};
        else if (branchD & ~stallD & ~flushD)
            ghr_d = {ghr_q[GHR_W-2:0], pred_takeD};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ghr_q <= '0;
        else      ghr_q <= ghr_d;
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (branchM) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (judgeM) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{pcF, pcM, l_cnt[0], g_cnt[0], c_cnt[0]};

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Bench for branch_predict_tournament: table-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_branch_predict_tournament;

    localparam int MW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   pcF = '0, pcM = '0;
    logic          stallD = 1'b0, flushD = 1'b0, branchD = 1'b0;
    logic          branchM = 1'b0, actual_takeM = 1'b0, judgeM = 1'b0;
    logic [MW-1:0] metaM = '0;
    logic          pred_takeD;
    logic [MW-1:0] metaD;
`ifdef BPU_STATS_EN
    logic [31:0]   stat_branches, stat_mispred;
`endif

    branch_predict_tournament dut (
        .clk          (clk),
        .rst          (rst),
        .pcF          (pcF),
        .stallD       (stallD),
        .flushD       (flushD),
        .branchD      (branchD),
        .pred_takeD   (pred_takeD),
        .metaD        (metaD),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .judgeM       (judgeM),
        .pcM          (pcM),
        .metaM        (metaM)
`ifdef BPU_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispred (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    // Reference state: plain integer counters/histories
    int            m_lpht [256];
    int            m_gpht [256];
    int            m_cpht [256];
    int            m_bht  [256];
    int            m_ghr;
    logic          m_pred_q;
    logic [MW-1:0] m_meta;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int sat(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            m_lpht[i] = 1; m_gpht[i] = 1; m_cpht[i] = 1; m_bht[i] = 0;
        end
        m_ghr = 0; m_pred_q = 1'b0; m_meta = '0;
    endfunction

    function automatic void model_step();
        int  fi, lhr, ghr_n, ml, ms, mi;
        bit  pl, pg, pred, ptd, a;
        fi   = int'((pcF >> 2) & 32'hFF);
        lhr  = m_bht[fi];
        pl   = (m_lpht[lhr] >= 2);
        pg   = (m_gpht[m_ghr ^ fi] >= 2);
        pred = (m_cpht[fi] >= 2) ? pg : pl;
        ptd  = branchD & m_pred_q;
        a    = actual_takeM;
        ghr_n = m_ghr;
        if (branchM && judgeM)
            ghr_n = ((int'(metaM >> 10) << 1) | int'(a)) & 255;
        else if (branchD && !stallD && !flushD)
            ghr_n = ((m_ghr << 1) | int'(ptd)) & 255;
        if (branchM) begin
            ml = int'((metaM >> 2) & 18'hFF);
            ms = int'(metaM >> 10);
            mi = int'((pcM >> 2) & 32'hFF);
            m_lpht[ml]      = sat(m_lpht[ml], a);
            m_gpht[ms ^ mi] = sat(m_gpht[ms ^ mi], a);
            m_bht[mi]       = ((ml << 1) | int'(a)) & 255;
            if (metaM[1] != metaM[0]) m_cpht[mi] = sat(m_cpht[mi], metaM[0] == a);
        end
        if (flushD) begin
            m_pred_q = 1'b0; m_meta = '0;
        end else if (!stallD) begin
            m_pred_q = pred;
            m_meta   = MW'((m_ghr << 10) | (lhr << 2) | (int'(pl) << 1) | int'(pg));
        end
        m_ghr = ghr_n;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_pred_takeD", 32'(pred_takeD), 32'(branchD & m_pred_q));
            chk("cyc_metaD", 32'(metaD), 32'(m_meta));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (rst) model_step();
        else     model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {stallD, flushD, branchD, branchM, judgeM, actual_takeM} = '0;
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic probe(input string name, input logic exp);
        branchD = 1'b1;
        #1;
        chk(name, 32'(pred_takeD), 32'(exp));
        branchD = 1'b0;
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input string name, input logic exp);
        pcF = pc;
        tick();
        probe(name, exp);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [MW-1:0] meta,
                           input logic a, input logic j);
        branchM = 1'b1; pcM = pc; metaM = meta; actual_takeM = a; judgeM = j;
        tick();
        branchM = 1'b0; judgeM = 1'b0;
    endtask

    task automatic run_branch(input logic [31:0] pc, input logic a);
        logic          p;
        logic [MW-1:0] m;
        pcF = pc; branchD = 1'b0;
        tick();
        branchD = 1'b1;
        p = m_pred_q;
        m = m_meta;
        tick();
        branchD = 1'b0;
        resolve(pc, m, a, p ^ a);
    endtask

    localparam logic [31:0] P = 32'hBFC0_0100;  // idx 0x40
    localparam logic [31:0] Q = 32'h0000_1000;  // idx 0x00
    localparam logic [31:0] C = 32'hBFC0_0200;  // idx 0x80
    localparam logic [31:0] X = 32'hBFC0_0300;  // idx 0xC0
    localparam logic [31:0] Y = 32'hBFC0_0400;  // idx 0x00

    initial begin
        logic [31:0] mix_pc [3];
        mix_pc[0] = 32'h0000_2000; mix_pc[1] = 32'h0000_2004; mix_pc[2] = 32'h0000_2108;

        // Reset holds the F/D register at zero even with a branch in D
        model_reset();
        pcF = P; branchD = 1'b1; chk_en = 1'b1;
        tick(); tick();
        chk("rst_pred", 32'(pred_takeD), 32'h0);
        chk("rst_meta", 32'(metaD), 32'h0);
        branchD = 1'b0; rst = 1'b1;
        tick();
        chk("rst_ghr", 32'(metaD[17:10]), 32'h0);

        // Loop training through the global path once choice favours global
        do_reset();
        for (int i = 0; i < 3; i++) resolve(P, 18'h00001, 1'b1, 1'b0);
        lookup(P, "loop_T3", 1'b1);
        resolve(P, 18'h00003, 1'b0, 1'b0);
        lookup(P, "loop_N1", 1'b1);
        resolve(P, 18'h00003, 1'b0, 1'b0);
        lookup(P, "loop_N2", 1'b0);

        // Speculative shifts then repair winning over a same-cycle shift
        do_reset();
        for (int i = 0; i < 2; i++) resolve(P, 18'h003FC, 1'b1, 1'b0);
        pcF = P; tick();
        branchD = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        branchD = 1'b0; tick();
        chk("spec_ghr", 32'(metaD[17:10]), 32'h07);
        branchD = 1'b1;
        resolve(P, 18'h003FC, 1'b0, 1'b1);
        branchD = 1'b0; tick();
        chk("repair_ghr", 32'(metaD[17:10]), 32'h00);

        // Stall holds the F/D register and GHR; flush beats stall
        do_reset();
        for (int i = 0; i < 2; i++) resolve(P, 18'h003FC, 1'b1, 1'b0);
        pcF = P; tick();
        chk("stall_pre_meta", 32'(metaD), 32'h003FF);
        pcF = Q; stallD = 1'b1; branchD = 1'b1;
        tick();
        chk("stall1_pred", 32'(pred_takeD), 32'h1);
        chk("stall1_meta", 32'(metaD), 32'h003FF);
        tick();
        chk("stall2_pred", 32'(pred_takeD), 32'h1);
        chk("stall2_meta", 32'(metaD), 32'h003FF);
        stallD = 1'b0; branchD = 1'b0; tick();
        chk("stall_ghr", 32'(metaD[17:10]), 32'h0);
        pcF = P; tick();
        flushD = 1'b1; stallD = 1'b1; branchD = 1'b1;
        tick();
        chk("flush_pred", 32'(pred_takeD), 32'h0);
        chk("flush_meta", 32'(metaD), 32'h0);
        flushD = 1'b0; stallD = 1'b0; branchD = 1'b0;
        tick();
        chk("flush_ghr", 32'(metaD[17:10]), 32'h0);

        // Choice: local-correct alternating T/N drives CPHT to 0 and saturates
        do_reset();
        resolve(C, 18'h00001, 1'b0, 1'b0);
        resolve(C, 18'h00002, 1'b1, 1'b0);
        resolve(C, 18'h00001, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) resolve(C, 18'h00203, 1'b1, 1'b0);
        lookup(C, "choice_agree", 1'b0);
        resolve(C, 18'h00201, 1'b1, 1'b0);
        lookup(C, "choice_sat0", 1'b0);
        resolve(C, 18'h00201, 1'b1, 1'b0);
        lookup(C, "choice_glob", 1'b1);

        // Same-cycle LPHT update and lookup: old value first, new value next
        do_reset();
        pcF = X;
        resolve(Y, 18'h00000, 1'b1, 1'b0);
        chk("coll_pl_old", 32'(metaD[1]), 32'h0);
        probe("coll_pred_old", 1'b0);
        tick();
        chk("coll_pl_new", 32'(metaD[1]), 32'h1);
        probe("coll_pred_new", 1'b1);

        // Mixed patterns checked against the model every cycle
        do_reset();
        for (int i = 0; i < 48; i++) begin
            case (i % 3)
                0: run_branch(mix_pc[0], 1'b1);
                1: run_branch(mix_pc[1], logic'((i / 3) % 2));
                default: run_branch(mix_pc[2], logic'(((i / 3) % 3) != 0));
            endcase
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
